// File: rtl/rmt_cmd_seq_if.sv
// Command/response bundle between a host, the rmt_cmd_seq sequencer and RemoteComm.
// Handshakes: wr_cmd, snd_cmd, cmd_snt and resp_rdy are one-cycle qualifiers, and data is valid only when its qualifier is high; there is no back-pressure, so a host must watch full.
interface rmt_cmd_seq_if;
  logic        wr_cmd;
  logic [15:0] cmd_in;
  logic        clr_err;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        full;
  logic        empty;
  logic        busy;
  logic [7:0]  done_cnt;
  logic        resp_err;
  logic        ovfl_err;
  logic        tmo_err;
  logic [7:0]  bad_resp;
  logic [2:0]  dbg_state;

  modport slave (
    input  wr_cmd, cmd_in, clr_err, cmd_snt, resp, resp_rdy,
    output snd_cmd, cmd, full, empty, busy, done_cnt,
           resp_err, ovfl_err, tmo_err, bad_resp, dbg_state
  );

  modport master (
    output wr_cmd, cmd_in, clr_err, cmd_snt, resp, resp_rdy,
    input  snd_cmd, cmd, full, empty, busy, done_cnt,
           resp_err, ovfl_err, tmo_err, bad_resp, dbg_state
  );
endinterface

// File: rtl/rmt_cmd_seq.sv
// Queued command sequencer for RemoteComm: FIFO of 16-bit commands, one transaction at a time.
// Define RMT_SEQ_TMO_EN to bound each transaction to TMO_CYC cycles (tmo_err otherwise tied low).
module rmt_cmd_seq #(
  parameter int DEPTH   = 4,
  parameter int TMO_CYC = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  rmt_cmd_seq_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SNT  = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_ERR       = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0] r_count;
  logic [15:0] r_cmd;
  logic [7:0]  r_done_cnt;
  logic        r_resp_err;
  logic        r_ovfl_err;
  logic [7:0]  r_bad_resp;

  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_ovfl;
  logic        w_good;
  logic        w_bad;
  logic        w_tmo_exp;
  logic        w_tmo_hit;
  logic        w_clr_in_err;

  assign w_full       = (r_count == (AW+1)'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_pop        = (r_state == ST_SEND);
  // A pop frees a slot in the same cycle, so a full queue still takes a write then.
  assign w_push       = bus.wr_cmd && (!w_full || w_pop);
  assign w_ovfl       = bus.wr_cmd && w_full && !w_pop;
  assign w_clr_in_err = (r_state == ST_ERR) && bus.clr_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.cmd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef RMT_SEQ_TMO_EN
  localparam int TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 2);

  logic [TW-1:0] r_tmo;
  logic          r_tmo_err;

  // Counter is 0 in the first wait cycle; firing one value early makes tmo_err visible TMO_CYC cycles after SEND.
  assign w_tmo_exp   = (r_tmo == TMO_LAST);
  assign bus.tmo_err = r_tmo_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo     <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      if (r_state == ST_SEND) begin
        r_tmo <= '0;
      end else if ((r_state == ST_WAIT_SNT) || (r_state == ST_WAIT_RESP)) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_tmo_hit) begin
        r_tmo_err <= 1'b1;
      end else if (w_clr_in_err) begin
        r_tmo_err <= 1'b0;
      end
    end
  end
`else
  // Waits are unbounded here; a legal TMO_CYC is never 0, so this never fires.
  assign w_tmo_exp   = (TMO_CYC == 0);
  assign bus.tmo_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_state_nxt = ST_WAIT_SNT;
      end
      ST_WAIT_SNT: begin
        // A response arriving before (or with) cmd_snt is not for this command.
        if (bus.cmd_snt) begin
          w_state_nxt = ST_WAIT_RESP;
        end else if (w_tmo_exp) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_ERR;
        end
      end
      ST_WAIT_RESP: begin
        if (bus.resp_rdy) begin
          if (bus.resp == 8'hA5) begin
            w_good      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_bad       = 1'b1;
            w_state_nxt = ST_ERR;
          end
        end else if (w_tmo_exp) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = ST_ERR;
        end
      end
      ST_ERR: begin
        if (bus.clr_err) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd      <= '0;
      r_done_cnt <= '0;
      r_resp_err <= 1'b0;
      r_ovfl_err <= 1'b0;
      r_bad_resp <= '0;
    end else begin
      // Load the head while leaving IDLE so cmd is already valid during the SEND pulse.
      if ((r_state == ST_IDLE) && !w_empty) begin
        r_cmd <= r_mem[r_rptr];
      end
      if (w_good) begin
        r_done_cnt <= r_done_cnt + 8'd1;
      end
      if (w_bad) begin
        r_resp_err <= 1'b1;
        r_bad_resp <= bus.resp;
      end else if (w_clr_in_err) begin
        r_resp_err <= 1'b0;
      end
      if (w_ovfl) begin
        r_ovfl_err <= 1'b1;
      end else if (bus.clr_err) begin
        r_ovfl_err <= 1'b0;
      end
    end
  end

  assign bus.snd_cmd   = (r_state == ST_SEND);
  assign bus.cmd       = r_cmd;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.done_cnt  = r_done_cnt;
  assign bus.resp_err  = r_resp_err;
  assign bus.ovfl_err  = r_ovfl_err;
  assign bus.bad_resp  = r_bad_resp;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_rmt_cmd_seq.sv
// Directed bench for rmt_cmd_seq with a RemoteComm stand-in and an in-order command scoreboard.
// Define RMT_SEQ_TMO_EN for both files to exercise the timeout path.
module tb_rmt_cmd_seq;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rmt_cmd_seq_if bus ();

  rmt_cmd_seq #(
    .DEPTH   (4),
    .TMO_CYC (100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp   = 0;
  int          n_fail  = 0;
  int          snd_cnt = 0;
  int          snd_mark;
  logic        prev_snd = 1'b0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [15:0] w, input bit accept);
    bus.cmd_in = w;
    bus.wr_cmd = 1'b1;
    if (accept) exp_q.push_back(w);
    tick();
    bus.wr_cmd = 1'b0;
  endtask

  task automatic wait_snd(input int budget);
    int start;
    bit seen;
    start = snd_cnt;
    seen  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (snd_cnt != start) begin
        seen = 1'b1;
        break;
      end
    end
    chk("snd_within_budget", 32'(seen), 32'd1);
  endtask

  task automatic serve(input logic [7:0] r);
    tick();
    bus.cmd_snt = 1'b1;
    tick();
    bus.cmd_snt  = 1'b0;
    bus.resp     = r;
    bus.resp_rdy = 1'b1;
    tick();
    bus.resp_rdy = 1'b0;
  endtask

  // RemoteComm side: every snd_cmd pulse must carry the next queued command.
  always @(negedge clk) begin
    if (rst_n && bus.snd_cmd) begin
      snd_cnt++;
      chk("snd_one_cycle", 32'(prev_snd), 32'd0);
      chk("snd_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("cmd_order", 32'(bus.cmd), 32'(exp_q.pop_front()));
    end
    prev_snd = bus.snd_cmd;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_cmd   = 1'b0;
    bus.cmd_in   = '0;
    bus.clr_err  = 1'b0;
    bus.cmd_snt  = 1'b0;
    bus.resp     = '0;
    bus.resp_rdy = 1'b0;
    rst_n        = 1'b0;
    ticks(3);
    chk("rst_status", 32'({bus.empty, bus.full, bus.busy, bus.snd_cmd}), 32'b1000);
    chk("rst_regs", 32'({bus.cmd, bus.done_cnt, bus.bad_resp}), 32'd0);
    chk("rst_errs", 32'({bus.resp_err, bus.ovfl_err, bus.tmo_err}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_release_state", 32'(bus.dbg_state), 32'd0);

    // Calibrate, with minimum latency N+2
    push(16'h2000, 1'b1);
    chk("lat_n1_snd", 32'(bus.snd_cmd), 32'd0);
    chk("lat_n1_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("lat_n2_snd", 32'(bus.snd_cmd), 32'd1);
    chk("lat_n2_cmd", 32'(bus.cmd), 32'h2000);
    serve(8'hA5);
    chk("cal_done", 32'(bus.done_cnt), 32'd1);
    chk("cal_busy", 32'(bus.busy), 32'd0);
    chk("cal_snd_count", 32'(snd_cnt), 32'd1);

    // Overflow while stalled in WAIT_SNT
    push(16'h1111, 1'b1);
    wait_snd(5);
    for (int i = 1; i <= 4; i++) push(16'h4000 + 16'(i), 1'b1);
    chk("ovf_stalled_state", 32'(bus.dbg_state), 32'd2);
    chk("ovf_full_before", 32'({bus.full, bus.ovfl_err}), 32'b10);
    push(16'h40FF, 1'b0);
    chk("ovf_flag", 32'({bus.full, bus.ovfl_err}), 32'b11);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("clr_outside_err", 32'({bus.ovfl_err, bus.full, bus.dbg_state}), 32'({1'b0, 1'b1, 3'd2}));
    serve(8'hA5);
    wait_snd(4);
    push(16'h4005, 1'b1);
    chk("full_write_with_pop", 32'({bus.full, bus.ovfl_err}), 32'b10);
    serve(8'hA5);
    for (int i = 0; i < 4; i++) begin
      wait_snd(4);
      serve(8'hA5);
    end
    chk("ovf_done", 32'(bus.done_cnt), 32'd7);
    chk("ovf_drained", 32'(bus.empty), 32'd1);

    // Bad response, including responses that must be ignored in WAIT_SNT
    push(16'h4001, 1'b1);
    push(16'h4002, 1'b1);
    wait_snd(4);
    tick();
    bus.resp     = 8'hA5;
    bus.resp_rdy = 1'b1;
    tick();
    bus.resp_rdy = 1'b0;
    chk("early_resp_ignored", 32'({bus.done_cnt, bus.dbg_state}), 32'({8'd7, 3'd2}));
    bus.cmd_snt  = 1'b1;
    bus.resp     = 8'h5A;
    bus.resp_rdy = 1'b1;
    tick();
    bus.cmd_snt  = 1'b0;
    bus.resp_rdy = 1'b0;
    chk("same_cycle_resp_ignored", 32'({bus.dbg_state, bus.resp_err, bus.bad_resp}), 32'({3'd3, 1'b0, 8'h00}));
    bus.resp_rdy = 1'b1;
    tick();
    bus.resp_rdy = 1'b0;
    chk("bad_resp_flags", 32'({bus.resp_err, bus.bad_resp, bus.busy}), 32'({1'b1, 8'h5A, 1'b1}));
    chk("bad_resp_state", 32'(bus.dbg_state), 32'd4);
    snd_mark = snd_cnt;
    push(16'h4003, 1'b1);
    ticks(10);
    chk("err_no_snd", 32'(snd_cnt), 32'(snd_mark));
    chk("err_queue_kept", 32'({bus.empty, bus.full}), 32'b00);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("err_cleared", 32'({bus.resp_err, bus.bad_resp, bus.dbg_state}), 32'({1'b0, 8'h5A, 3'd0}));
    wait_snd(4);
    serve(8'hA5);
    wait_snd(4);
    serve(8'hA5);
    chk("err_resume_done", 32'(bus.done_cnt), 32'd9);

    // Back-to-back: one IDLE cycle between transactions
    push(16'h7001, 1'b1);
    push(16'h7002, 1'b1);
    wait_snd(4);
    serve(8'hA5);
    chk("b2b_idle_gap", 32'({bus.busy, bus.snd_cmd}), 32'b00);
    tick();
    chk("b2b_send", 32'({bus.snd_cmd, bus.cmd}), 32'({1'b1, 16'h7002}));
    serve(8'hA5);
    chk("b2b_done", 32'(bus.done_cnt), 32'd11);

    // Timeout (or unbounded wait when the timeout is not built in)
    push(16'h8001, 1'b1);
    wait_snd(4);
`ifdef RMT_SEQ_TMO_EN
    ticks(99);
    chk("tmo_not_yet", 32'({bus.tmo_err, bus.dbg_state}), 32'({1'b0, 3'd2}));
    tick();
    chk("tmo_at_100", 32'({bus.tmo_err, bus.dbg_state}), 32'({1'b1, 3'd4}));
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("tmo_cleared", 32'({bus.tmo_err, bus.dbg_state}), 32'({1'b0, 3'd0}));
`else
    ticks(150);
    chk("no_tmo_wait", 32'({bus.tmo_err, bus.dbg_state}), 32'({1'b0, 3'd2}));
    serve(8'hA5);
    chk("no_tmo_done", 32'(bus.done_cnt), 32'd12);
`endif

    // Reset in WAIT_RESP with three words queued
    push(16'h5001, 1'b1);
    wait_snd(4);
    tick();
    bus.cmd_snt = 1'b1;
    tick();
    bus.cmd_snt = 1'b0;
    for (int i = 2; i <= 4; i++) push(16'h5000 + 16'(i), 1'b0);
    chk("pre_rst_state", 32'({bus.dbg_state, bus.empty}), 32'({3'd3, 1'b0}));
    rst_n = 1'b0;
    tick();
    chk("mid_rst", 32'({bus.empty, bus.done_cnt, bus.busy, bus.snd_cmd}), 32'({1'b1, 8'd0, 1'b0, 1'b0}));
    rst_n = 1'b1;
    snd_mark = snd_cnt;
    ticks(10);
    chk("post_rst_no_snd", 32'(snd_cnt), 32'(snd_mark));

    // Pointer wrap, then done_cnt wrap past 255
    for (int i = 0; i < 10; i++) begin
      push(16'h6000 + 16'(i), 1'b1);
      wait_snd(4);
      serve(8'hA5);
    end
    chk("wrap_done_10", 32'(bus.done_cnt), 32'd10);
    chk("wrap_all_sent", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 246; i++) begin
      push(16'(i * 7), 1'b1);
      wait_snd(4);
      serve(8'hA5);
    end
    chk("done_cnt_wrap", 32'(bus.done_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rmt_cmd_seq.md
RMT_CMD_SEQ -- requirements
Module: rmt_cmd_seq

Interface
REQ-001 Parameter DEPTH, default 4, command queue depth in entries; power of 2, range 2..16.
REQ-002 Parameter TMO_CYC, default 1000000, clk cycles allowed per transaction before timeout.
REQ-003 clk  input  1  system clock; one clock domain, all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 wr_cmd  input  1  one-cycle pulse that pushes cmd_in into the queue.
REQ-006 cmd_in  input  16  command word to enqueue, e.g. 16'h2000 calibrate or 16'h4001 move north 1.
REQ-007 clr_err  input  1  clears sticky errors and releases the ERR state.
REQ-008 snd_cmd  output  1  one-cycle pulse to RemoteComm to start a command transmission.
REQ-009 cmd  output  16  command word to RemoteComm.
REQ-010 cmd_snt  input  1  from RemoteComm: both command bytes have been transmitted.
REQ-011 resp  input  8  response byte from RemoteComm.
REQ-012 resp_rdy  input  1  from RemoteComm: resp is valid.
REQ-013 full, empty  output  1 each  queue status.
REQ-014 busy  output  1  high in every state other than IDLE.
REQ-015 done_cnt  output  8  count of good (8'hA5) responses.
REQ-016 resp_err, ovfl_err, tmo_err  output  1 each  sticky error flags.
REQ-017 bad_resp  output  8  last response byte that was not 8'hA5.

Function
REQ-018 Queue is a FIFO of DEPTH 16-bit entries with wrapping read/write pointers and an occupancy count.
REQ-019 wr_cmd with full=1 shall drop the word and set ovfl_err.
REQ-020 Exception: a write in the same cycle as a pop while full shall be accepted.
REQ-021 State machine states: IDLE, SEND, WAIT_SNT, WAIT_RESP, ERR.
REQ-022 IDLE: if empty=0, go to SEND next cycle; otherwise stay in IDLE.
REQ-023 SEND, exactly one cycle: snd_cmd=1; cmd takes the queue head; the head is popped; timeout counter clears; go to WAIT_SNT.
REQ-024 cmd shall be registered and held stable from SEND until the next SEND.
REQ-025 WAIT_SNT: on cmd_snt=1, go to WAIT_RESP; a resp_rdy seen in this state is ignored.
REQ-026 WAIT_RESP, resp_rdy=1 with resp==8'hA5: increment done_cnt (wraps 255 to 0) and go to IDLE.
REQ-027 WAIT_RESP, resp_rdy=1 with any other resp: capture resp in bad_resp, set resp_err, go to ERR.
REQ-028 cmd_snt and resp_rdy in the same cycle in WAIT_SNT: go to WAIT_RESP only; that resp is not evaluated.
REQ-029 ERR: snd_cmd stays 0; the queue keeps its contents and still accepts writes.
REQ-030 ERR: clr_err=1 goes to IDLE and clears resp_err, tmo_err and ovfl_err; bad_resp is kept.
REQ-031 clr_err outside ERR clears only ovfl_err.
REQ-032 Minimum latency: wr_cmd into an empty queue at cycle N gives snd_cmd=1 at cycle N+2.
REQ-033 Back-to-back commands: IDLE is visited for one cycle between transactions.

Reset
REQ-034 When rst_n=0 at a clk edge: state=IDLE, queue emptied, and snd_cmd=0, cmd=0, done_cnt=0, all error flags 0, bad_resp=0.
REQ-035 Status outputs after reset: empty=1, full=0, busy=0.
REQ-036 Reset during any transaction, including mid-UART, shall abort it with no snd_cmd issued.

Configuration
REQ-037 Macro RMT_SEQ_TMO_EN defined: a transaction counter runs in WAIT_SNT and WAIT_RESP.
REQ-038 When the counter reaches TMO_CYC-1 without the awaited event: set tmo_err, go to ERR.
REQ-039 Macro RMT_SEQ_TMO_EN undefined: no counter logic; tmo_err is tied to 0; the waits are unbounded.

Verification
REQ-040 Calibrate, good response: push 16'h2000, model returns cmd_snt then resp 8'hA5 -> snd_cmd pulses once with cmd=16'h2000, done_cnt=1, busy returns to 0.
REQ-041 Overflow: push 5 words with DEPTH=4 and the FSM stalled in WAIT_SNT -> ovfl_err=1, 4 words retained, sent in FIFO order 16'h4001, 16'h4002, 16'h4003, 16'h4004.
REQ-042 Bad response: push 16'h4001, answer 8'h5A -> resp_err=1, bad_resp=8'h5A, ERR with no further snd_cmd; then clr_err -> next queued command is sent.
REQ-043 Timeout: with RMT_SEQ_TMO_EN and TMO_CYC=100, never assert cmd_snt -> tmo_err=1 exactly 100 cycles after SEND.
REQ-044 Reset mid-operation: assert rst_n=0 in WAIT_RESP with 3 words queued -> next cycle empty=1, done_cnt=0, busy=0, no snd_cmd for 10 cycles.
REQ-045 Pointer wrap: 10 push/complete cycles with good responses -> done_cnt=10, commands received in order.
